// File: rtl/m68k_bus_pkg.sv
// Shared encodings and limits for the 68010 local-bus arbiter.
package m68k_bus_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int OWNER_W     = $clog2(MAX_MASTERS);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQ      = 3'd1;
  localparam logic [2:0] ST_WAIT_BUS = 3'd2;
  localparam logic [2:0] ST_OWN      = 3'd3;
  localparam logic [2:0] ST_HANDOFF  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_REQ      = ST_REQ,
    S_WAIT_BUS = ST_WAIT_BUS,
    S_OWN      = ST_OWN,
    S_HANDOFF  = ST_HANDOFF
  } arb_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous active-low bus pins; idles high.
module sync2 (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Shares the 68010 local bus between the CPU and round-robin DMA masters
// using the BR/BG/BGACK handshake.
module m68k_bus_arbiter
  import m68k_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int BG_TIMEOUT  = 255
) (
  input  logic                   C100,
  input  logic                   reset,
  input  logic                   P_BG_n,
  input  logic                   P_AS_n,
  output logic                   P_BR_n,
  output logic                   P_BGACK_n,
  input  logic [NUM_MASTERS-1:0] dma_req,
  output logic [NUM_MASTERS-1:0] dma_grant,
  output logic [2:0]             bus_owner,
  output logic                   bg_timeout
);

  arb_state_e             state_q, state_d;
  logic                   br_n_q, br_n_d;
  logic                   bgack_n_q, bgack_n_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     last_q, last_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  logic                   bg_s, as_s;
  logic                   any_req, owner_req;
  logic [OWNER_W-1:0]     win;
  logic [NUM_MASTERS-1:0] win_onehot;

  // First requester strictly after `last`, wrapping; `last` itself is tried last.
  function automatic logic [OWNER_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                 input logic [OWNER_W-1:0]     last);
    logic [OWNER_W-1:0]     pick;
    logic [NUM_MASTERS-1:0] shifted;
    int                     idx;
    pick = last;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx     = (int'(last) + k) % NUM_MASTERS;
      shifted = req >> idx;
      if (shifted[0]) pick = OWNER_W'(idx);
    end
    return pick;
  endfunction

  sync2 u_sync_bg (.clk(C100), .srst(reset), .d(P_BG_n), .q(bg_s));
  sync2 u_sync_as (.clk(C100), .srst(reset), .d(P_AS_n), .q(as_s));

  assign any_req   = |dma_req;
  assign owner_req = |(dma_req & grant_q);
  assign win       = rr_pick(dma_req, last_q);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
      assign win_onehot[gi] = (win == OWNER_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    br_n_d    = br_n_q;
    bgack_n_d = bgack_n_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_REQ;
          br_n_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (!any_req) begin
          br_n_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!bg_s) begin
          state_d = S_WAIT_BUS;
        end else if (int'(cnt_q) >= BG_TIMEOUT) begin
          timeout_d = 1'b1;
          br_n_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT_BUS: begin
        // The CPU's last cycle must finish and no earlier tenure may still hold BGACK.
        if (!any_req) begin
          br_n_d  = 1'b1;
          state_d = S_IDLE;
        end else if (as_s && bgack_n_q) begin
          br_n_d    = 1'b1;
          bgack_n_d = 1'b0;
          grant_d   = win_onehot;
          owner_d   = win;
          last_d    = win;
          state_d   = S_OWN;
        end
      end
      S_OWN: begin
        if (!owner_req) begin
          grant_d = '0;
          state_d = S_HANDOFF;
        end
      end
      S_HANDOFF: begin
        // BGACK is still held, so the next master takes over without a new BR/BG exchange.
        if (any_req) begin
          grant_d = win_onehot;
          owner_d = win;
          last_d  = win;
          state_d = S_OWN;
        end else begin
          bgack_n_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge C100) begin
    if (reset) begin
      state_q   <= S_IDLE;
      br_n_q    <= 1'b1;
      bgack_n_q <= 1'b1;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= OWNER_W'(NUM_MASTERS - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_n_q    <= br_n_d;
      bgack_n_q <= bgack_n_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign P_BR_n     = br_n_q;
  assign P_BGACK_n  = bgack_n_q;
  assign dma_grant  = grant_q;
  assign bus_owner  = owner_q;
  assign bg_timeout = timeout_q;

endmodule
